dp_result_stage: RTL and testbench

//  Downstream stage of the arithmetic datapath. Captures Y/co from the datapath
//  and derives Z/N/C/V flags. Buffers {flags,Y} in a small FIFO with a

---
 rtl/dp_result_stage.sv | 110 +++++++++++
 tb/tb_dp_result_stage.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dp_result_stage.sv
// dp_result_stage: captures datapath Y/co, derives {Z,N,C,V}, buffers results in a FIFO with credit-based issue
// Ports: clk, rst_n (sync, active-low); issue side in_valid/in_ready/in_opcode/in_a_msb/in_b_msb;
//        datapath side dp_y/dp_co (LAT cycles after issue); output side out_valid/out_ready/out_y/out_flags;
//        drop_err is sticky, set by an issue attempt without credit.
// Optional: define SAT_EN to saturate stored Y on signed overflow.
module dp_result_stage #(
    parameter int N     = 16,
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_opcode,
    input  logic         in_a_msb,
    input  logic         in_b_msb,
    input  logic [N-1:0] dp_y,
    input  logic         dp_co,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_y,
    output logic [3:0]   out_flags,
    output logic         drop_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;
    logic          acc, cap, cap_a, cap_b, sbe, v, push, pop;
    logic [2:0]    cap_op;
    logic [CW-1:0] inflight;
    logic [N-1:0]  y_st;
    logic [N+3:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q, count_d;
    logic          drop_err_q;
    assign acc = in_valid & in_ready;
    generate
        if (LAT == 0) begin : g_nodl
            assign cap      = acc;
            assign cap_op   = in_opcode;
            assign cap_a    = in_a_msb;
            assign cap_b    = in_b_msb;
            assign inflight = '0;
        end else begin : g_dl
            logic [LAT-1:0] acc_q, a_q, b_q;
            logic [2:0]     op_q [LAT];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    acc_q <= '0;
                    a_q   <= '0;
                    b_q   <= '0;
                    for (int i = 0; i < LAT; i++) op_q[i] <= '0;
                end else begin
                    acc_q[0] <= acc;
                    a_q[0]   <= in_a_msb;
                    b_q[0]   <= in_b_msb;
                    op_q[0]  <= in_opcode;
                    for (int i = 1; i < LAT; i++) begin
                        acc_q[i] <= acc_q[i-1];
                        a_q[i]   <= a_q[i-1];
                        b_q[i]   <= b_q[i-1];
                        op_q[i]  <= op_q[i-1];
                    end
                end
            end
            assign cap    = acc_q[LAT-1];
            assign cap_op = op_q[LAT-1];
            assign cap_a  = a_q[LAT-1];
            assign cap_b  = b_q[LAT-1];
            // Results already issued but not yet captured still hold a FIFO credit.
            always_comb begin
                inflight = '0;
                for (int i = 0; i < LAT; i++) inflight = inflight + CW'(acc_q[i]);
            end
        end
    endgenerate
    // Immediate-operand opcodes carry the effective B sign in opcode[1].
    assign sbe = cap_op[2] ? cap_op[1] : (cap_b ^ cap_op[1]);
    assign v   = (cap_a == sbe) & (dp_y[N-1] != cap_a);
`ifdef SAT_EN
    assign y_st = v ? (cap_a ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}}) : dp_y;
`else
    assign y_st = dp_y;
`endif
    assign push      = cap;
    assign pop       = out_valid & out_ready;
    assign count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
    assign out_valid = count_q != '0;
    assign out_y     = out_valid ? mem_q[rd_q][N-1:0] : '0;
    assign out_flags = out_valid ? mem_q[rd_q][N+3:N] : '0;
    assign in_ready  = (CW'(count_q) + inflight) < CW'(DEPTH);
    assign drop_err  = drop_err_q;
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {y_st == '0, y_st[N-1], dp_co, v, y_st};
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            drop_err_q <= 1'b0;
        end else begin
            assert (!push || count_q < (AW+1)'(DEPTH));
            wr_q       <= push ? wr_q + 1'b1 : wr_q;
            rd_q       <= pop ? rd_q + 1'b1 : rd_q;
            count_q    <= count_d;
            drop_err_q <= drop_err_q | (in_valid & ~in_ready);
        end
    end
endmodule

// File: tb/tb_dp_result_stage.sv
// tb_dp_result_stage: directed checks of dp_result_stage with N=16, LAT=1, DEPTH=4
module tb_dp_result_stage;
    logic        clk, rst_n, in_valid, in_ready, in_a_msb, in_b_msb, dp_co;
    logic        out_valid, out_ready, drop_err;
    logic [2:0]  in_opcode;
    logic [15:0] dp_y, out_y;
    logic [3:0]  out_flags;
    logic [15:0] py;
    logic        pc;
    int          total, bad;
    logic [15:0] q[$];
    logic [15:0] seq;
`ifdef SAT_EN
    localparam logic [15:0] Y1 = 16'h7FFF;
    localparam logic [3:0]  F1 = 4'b0001;
    localparam logic [15:0] Y5 = 16'h8000;
    localparam logic [3:0]  F5 = 4'b0111;
`else
    localparam logic [15:0] Y1 = 16'h8000;
    localparam logic [3:0]  F1 = 4'b0101;
    localparam logic [15:0] Y5 = 16'h7FFF;
    localparam logic [3:0]  F5 = 4'b0011;
`endif
    dp_result_stage #(.N(16), .LAT(1), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
        .dp_y(dp_y), .dp_co(dp_co), .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_flags(out_flags), .drop_err(drop_err)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // One clock: datapath output for the previous issue plus the new issue, then sample #1 after the edge.
    task automatic step(input logic v, input logic [2:0] op, input logic am, input logic bm,
                        input logic [15:0] y, input logic co);
        dp_y = py;
        dp_co = pc;
        in_valid = v;
        in_opcode = op;
        in_a_msb = am;
        in_b_msb = bm;
        py = y;
        pc = co;
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        step(1'b0, 3'b000, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask
    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_a_msb = 1'b0; in_b_msb = 1'b0;
        dp_y = '0; dp_co = 1'b0; out_ready = 1'b0; py = '0; pc = 1'b0;
        idle(); idle();
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_drop_err", drop_err, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_flags", out_flags, 0);
        // 0x7FFF + 0x0001 overflows positive
        step(1'b1, 3'b000, 1'b0, 1'b0, 16'h8000, 1'b0);
        idle();
        chk("t1_valid", out_valid, 1);
        chk("t1_y", out_y, Y1);
        chk("t1_flags", out_flags, F1);
        out_ready = 1'b1;
        idle();
        chk("t1_popped", out_valid, 0);
        out_ready = 1'b0;
        // 5 - 5: zero with no borrow
        step(1'b1, 3'b011, 1'b0, 1'b0, 16'h0000, 1'b1);
        chk("t2_valid_early", out_valid, 0);
        idle();
        chk("t2_valid", out_valid, 1);
        chk("t2_y", out_y, 16'h0000);
        chk("t2_flags", out_flags, 4'b1010);
        out_ready = 1'b1;
        idle();
        out_ready = 1'b0;
        // 0x8000 - 1 overflows negative
        step(1'b1, 3'b110, 1'b1, 1'b0, 16'h7FFF, 1'b1);
        idle();
        chk("t5_y", out_y, Y5);
        chk("t5_flags", out_flags, F5);
        out_ready = 1'b1;
        idle();
        chk("t5_popped", out_valid, 0);
        out_ready = 1'b0;
        // Credit exhaustion with a stalled consumer
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 3'b000, 1'b0, 1'b0, 16'(i), 1'b0);
            if (i == 3) chk("t3_ready_3", in_ready, 1);
        end
        chk("t3_ready_4", in_ready, 0);
        step(1'b1, 3'b000, 1'b0, 1'b0, 16'h0099, 1'b0);
        chk("t3_drop_err", drop_err, 1);
        chk("t3_full_valid", out_valid, 1);
        chk("t3_full_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("t3_order", out_y, k);
            chk("t3_flags", out_flags, 0);
            idle();
        end
        chk("t3_empty", out_valid, 0);
        chk("t3_ready_again", in_ready, 1);
        chk("t3_drop_sticky", drop_err, 1);
        out_ready = 1'b0;
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        chk("t3_rst_drop", drop_err, 0);
        // Full FIFO then continuous streaming across pointer wrap
        for (int i = 0; i < 4; i++) begin
            q.push_back(16'h10 + 16'(i));
            step(1'b1, 3'b000, 1'b0, 1'b0, 16'h10 + 16'(i), 1'b0);
        end
        idle();
        chk("t4_full_ready", in_ready, 0);
        out_ready = 1'b1;
        seq = 16'h20;
        for (int i = 0; i < 14; i++) begin
            if (out_valid) begin
                chk("t4_head", out_y, q[0]);
                void'(q.pop_front());
            end
            if (i >= 1) chk("t4_stream_ready", in_ready, 1);
            if (in_ready) begin
                q.push_back(seq);
                step(1'b1, 3'b000, 1'b0, 1'b0, seq, 1'b0);
                seq++;
            end else idle();
        end
        for (int i = 0; i < 8; i++) begin
            if (out_valid) begin
                chk("t4_drain", out_y, q[0]);
                void'(q.pop_front());
            end
            idle();
        end
        chk("t4_all_out", q.size(), 0);
        chk("t4_no_drop", drop_err, 0);
        chk("t4_empty", out_valid, 0);
        // Reset with two queued and one in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 3'b000, 1'b0, 1'b0, 16'h31 + 16'(i), 1'b0);
        chk("t6_queued", out_valid, 1);
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        chk("t6_valid", out_valid, 0);
        chk("t6_ready", in_ready, 1);
        chk("t6_drop", drop_err, 0);
        chk("t6_y", out_y, 0);
        idle();
        idle();
        chk("t6_no_late_push", out_valid, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
